// File: rtl/gray_step_scheduler_pkg.sv
// Shared types for the Gray counter step scheduler: FSM states and requester ids.
package gray_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_MAN  = 1'b0,
        REQ_AUTO = 1'b1
    } req_e;

    function automatic req_e other_req(input req_e r);
        return (r == REQ_MAN) ? REQ_AUTO : REQ_MAN;
    endfunction

endpackage

// File: rtl/gray_step_scheduler_if.sv
// Request/step bundle between the pulse generators, the scheduler and the Gray counter.
interface gray_step_scheduler_if #(
    parameter int unsigned CW = 3
);
    logic          man_req;
    logic          auto_req;
    logic          hold;
    logic          step;
    logic          grant_man;
    logic          grant_auto;
    logic [CW-1:0] pend_man;
    logic [CW-1:0] pend_auto;
    logic          ovf;

    modport master (
        output man_req, auto_req, hold,
        input  step, grant_man, grant_auto, pend_man, pend_auto, ovf
    );

    modport slave (
        input  man_req, auto_req, hold,
        output step, grant_man, grant_auto, pend_man, pend_auto, ovf
    );
endinterface

// File: rtl/gray_step_scheduler_credit.sv
// Saturating per-requester credit counter; a request at a full queue is dropped and flagged.
module gray_credit_counter #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          drop
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          full;

    assign full  = (count_q == FULL);
    assign drop  = inc && !dec && full;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + CW'(1);
        end else if (!inc && dec && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gray_step_scheduler.sv
// Merges manual and auto step requests into one spaced clk_en pulse stream,
// queueing requests per requester and alternating between them on ties.
module gray_step_scheduler
    import gray_sys_pkg::*;
#(
    parameter int unsigned GAP   = 4,
    parameter int unsigned DEPTH = 7,
    parameter int unsigned CW    = 3
) (
    input logic                  clk,
    input logic                  rst,
    gray_step_scheduler_if.slave bus
);

    localparam int unsigned     GW       = (GAP > 2) ? $clog2(GAP - 1) : 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP - 2);
    localparam bit              NO_GAP   = (GAP == 2);

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    req_e          rr_q, rr_d;
    logic          step_q, step_d;
    logic          gman_q, gman_d;
    logic          gauto_q, gauto_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] pend_man, pend_auto;
    logic          drop_man, drop_auto;
    logic          man_nz, auto_nz;
    req_e          winner;

    gray_credit_counter #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_cred_man (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.man_req),
        .dec   (gman_q),
        .count (pend_man),
        .drop  (drop_man)
    );

    gray_credit_counter #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_cred_auto (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.auto_req),
        .dec   (gauto_q),
        .count (pend_auto),
        .drop  (drop_auto)
    );

    assign man_nz  = (pend_man != '0);
    assign auto_nz = (pend_auto != '0);
    assign winner  = (man_nz && auto_nz) ? rr_q : (man_nz ? REQ_MAN : REQ_AUTO);

    // ISSUE plus (GAP-2) GAP cycles plus one IDLE cycle puts steps exactly GAP apart;
    // with GAP==2 there is no GAP cycle at all.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        step_d  = 1'b0;
        gman_d  = 1'b0;
        gauto_d = 1'b0;
        ovf_d   = ovf_q | drop_man | drop_auto;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.hold && (man_nz || auto_nz)) begin
                    state_d = ST_ISSUE;
                    step_d  = 1'b1;
                    gman_d  = (winner == REQ_MAN);
                    gauto_d = (winner == REQ_AUTO);
                end
            end
            ST_ISSUE: begin
                rr_d    = other_req(gman_q ? REQ_MAN : REQ_AUTO);
                gap_d   = GAP_LOAD;
                state_d = NO_GAP ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            rr_q    <= REQ_MAN;
            step_q  <= 1'b0;
            gman_q  <= 1'b0;
            gauto_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            step_q  <= step_d;
            gman_q  <= gman_d;
            gauto_q <= gauto_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.grant_man  = gman_q;
    assign bus.grant_auto = gauto_q;
    assign bus.pend_man   = pend_man;
    assign bus.pend_auto  = pend_auto;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_gray_step_scheduler.sv
// Directed scenarios plus random traffic for gray_step_scheduler, checked against a
// cycle-level model built from credit counts and a next-allowed-step edge index.
module tb_gray_step_scheduler;

    localparam int GAP   = 4;
    localparam int DEPTH = 7;
    localparam int CW    = 3;

    logic clk;
    logic rst;

    gray_step_scheduler_if #(.CW(CW)) bus ();

    gray_step_scheduler #(
        .GAP   (GAP),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cm, m_ca;
    bit m_ovf;
    bit m_rr_man;
    bit m_dm, m_da;
    bit m_step, m_gm, m_ga;
    int m_edge, m_next_ok;

    int nsteps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cm = 0; m_ca = 0; m_ovf = 0; m_rr_man = 1;
        m_dm = 0; m_da = 0; m_step = 0; m_gm = 0; m_ga = 0;
        m_edge = 0; m_next_ok = 0;
    endtask

    task automatic credit(inout int c, input bit inc, input bit dec);
        if (inc && !dec) begin
            if (c == DEPTH) m_ovf = 1;
            else c++;
        end else if (!inc && dec && c > 0) begin
            c--;
        end
    endtask

    task automatic check_model();
        chk("step",       {31'd0, bus.step},       {31'd0, m_step});
        chk("grant_man",  {31'd0, bus.grant_man},  {31'd0, m_gm});
        chk("grant_auto", {31'd0, bus.grant_auto}, {31'd0, m_ga});
        chk("pend_man",   32'(bus.pend_man),       32'(m_cm));
        chk("pend_auto",  32'(bus.pend_auto),      32'(m_ca));
        chk("ovf",        {31'd0, bus.ovf},        {31'd0, m_ovf});
    endtask

    // One clock edge: model reacts to the inputs present at the edge, DUT sampled on negedge.
    task automatic tick();
        bit iss, w_man, dm, da;
        @(posedge clk);
        iss   = (m_edge >= m_next_ok) && !bus.hold && (m_cm > 0 || m_ca > 0);
        w_man = (m_cm > 0 && m_ca > 0) ? m_rr_man : (m_cm > 0);
        dm = m_dm;
        da = m_da;
        credit(m_cm, bus.man_req, dm);
        credit(m_ca, bus.auto_req, da);
        m_dm   = iss && w_man;
        m_da   = iss && !w_man;
        m_step = iss;
        m_gm   = iss && w_man;
        m_ga   = iss && !w_man;
        if (iss) begin
            m_next_ok = m_edge + GAP;
            m_rr_man  = !w_man;
        end
        m_edge++;
        @(negedge clk);
        check_model();
        if (bus.step === 1'b1) nsteps++;
    endtask

    task automatic pulse(input bit man, input bit aut);
        bus.man_req  = man;
        bus.auto_req = aut;
        tick();
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_step"},  {31'd0, bus.step},       32'd0);
        chk({tag, "_gman"},  {31'd0, bus.grant_man},  32'd0);
        chk({tag, "_gauto"}, {31'd0, bus.grant_auto}, 32'd0);
        chk({tag, "_pman"},  32'(bus.pend_man),       32'd0);
        chk({tag, "_pauto"}, 32'(bus.pend_auto),      32'd0);
        chk({tag, "_ovf"},   {31'd0, bus.ovf},        32'd0);
    endtask

    initial begin
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
        bus.hold     = 1'b0;
        nsteps       = 0;
        model_reset();

        // Power-on reset
        rst = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();

        // Single manual request: step two edges later, then nothing
        pulse(1'b1, 1'b0);
        chk("single_pend1", 32'(bus.pend_man), 32'd1);
        chk("single_nostep", {31'd0, bus.step}, 32'd0);
        tick();
        chk("single_step", {31'd0, bus.step}, 32'd1);
        chk("single_gman", {31'd0, bus.grant_man}, 32'd1);
        tick();
        chk("single_pend0", 32'(bus.pend_man), 32'd0);
        nsteps = 0;
        repeat (10) tick();
        chk("single_nomore", 32'(nsteps), 32'd0);

        // Saturation under hold, then drain
        bus.hold = 1'b1;
        repeat (9) pulse(1'b1, 1'b0);
        chk("sat_pend", 32'(bus.pend_man), 32'd7);
        chk("sat_ovf", {31'd0, bus.ovf}, 32'd1);
        bus.hold = 1'b0;
        nsteps = 0;
        repeat (40) tick();
        chk("sat_steps", 32'(nsteps), 32'd7);
        chk("sat_drained", 32'(bus.pend_man), 32'd0);
        chk("sat_ovf_sticky", {31'd0, bus.ovf}, 32'd1);

        // Request during the ISSUE cycle that consumes manual credit
        bus.hold = 1'b1;
        repeat (2) pulse(1'b1, 1'b0);
        bus.hold = 1'b0;
        tick();
        chk("conc_step", {31'd0, bus.grant_man}, 32'd1);
        pulse(1'b1, 1'b0);
        chk("conc_pend", 32'(bus.pend_man), 32'd2);
        repeat (20) tick();

        // Hold raised during a GAP
        bus.hold = 1'b1;
        repeat (3) pulse(1'b0, 1'b1);
        bus.hold = 1'b0;
        tick();
        chk("hold_first", {31'd0, bus.grant_auto}, 32'd1);
        tick();
        bus.hold = 1'b1;
        nsteps = 0;
        repeat (8) tick();
        chk("hold_nostep", 32'(nsteps), 32'd0);
        chk("hold_pend", 32'(bus.pend_auto), 32'd2);
        bus.hold = 1'b0;
        tick();
        chk("hold_release", {31'd0, bus.step}, 32'd1);
        repeat (20) tick();

        // Async reset mid-GAP with manual backlog
        bus.hold = 1'b1;
        repeat (6) pulse(1'b1, 1'b0);
        bus.hold = 1'b0;
        tick();
        tick();
        chk("ar_pend", 32'(bus.pend_man), 32'd5);
        #2 rst = 1'b0;
        #1;
        check_zero("areset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();

        // Tie after reset: manual first, auto GAP cycles later
        pulse(1'b1, 1'b1);
        tick();
        chk("tie_man", {31'd0, bus.grant_man}, 32'd1);
        repeat (3) tick();
        tick();
        chk("tie_auto", {31'd0, bus.grant_auto}, 32'd1);
        repeat (6) tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.man_req  = ($urandom_range(0, 3) == 0);
            bus.auto_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) bus.hold = ~bus.hold;
            tick();
        end
        bus.man_req  = 1'b0;
        bus.auto_req = 1'b0;
        bus.hold     = 1'b0;
        repeat (70) tick();
        chk("final_man", 32'(bus.pend_man), 32'd0);
        chk("final_auto", 32'(bus.pend_auto), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_step_scheduler.md
Name: gray_step_scheduler

Overview:
- Arbitrates step requests from the manual-button path and the auto/speed-pulse path into one clean clk_en stream for the N-bit Gray counter.
- Requests that arrive while a step is in flight are queued per requester, never ORed together and silently merged.
- Enforces a minimum spacing between counter steps.
- Sits between the two pulse generators and the Gray counter's clk_en input inside the Gray counter system.

Parameters:
- GAP, 4, minimum cycles between consecutive step assertions (>=2).
- DEPTH, 7, max queued requests per requester (1..2^CW-1).
- CW, 3, width of each credit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- man_req  in  1  single-cycle request from manual path.
- auto_req  in  1  single-cycle request from speed path.
- hold  in  1  level; blocks new step issue while high.
- step  out  1  registered one-cycle enable to Gray counter clk_en.
- grant_man  out  1  registered; high with step when manual credit consumed.
- grant_auto  out  1  registered; high with step when auto credit consumed.
- pend_man  out  CW  manual credits outstanding.
- pend_auto  out  CW  auto credits outstanding.
- ovf  out  1  sticky; request dropped due to full queue.

Behaviour:
- Reset (rst=0, async): step, grants, pend_man, pend_auto, ovf = 0; FSM=IDLE; gap counter = 0; rr pointer = MAN (manual wins first tie).
- Credit update per requester, each rising edge:
  - Net change = +req − consumed.
  - req and consume in the same cycle: count unchanged.
  - req while count==DEPTH and not consumed: request dropped, ovf<=1 (held until reset).
  - Never wraps; never goes below 0.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If hold==0 and (pend_man>0 or pend_auto>0), go to ISSUE.
  - Winner selection: the only nonzero requester; if both are nonzero, the requester at the rr pointer.
  - Credit counts are sampled from registered values, so a request sampled at edge t can win at edge t+1.
- ISSUE (exactly 1 cycle):
  - step=1 and matching grant=1.
  - Winner's credit decremented at the end of this cycle.
  - rr pointer moves to the other requester.
  - Gap counter loaded with GAP-2; go to GAP.
- GAP:
  - Counter decrements each cycle; at 0 go to IDLE.
  - With continuous backlog, step pulses are exactly GAP cycles apart.
- hold:
  - Only gates the IDLE→ISSUE transition.
  - A GAP already in progress completes.
  - Requests keep accumulating.
  - Deasserting hold gives ISSUE on the next edge.
- Latency: request sampled at edge t (IDLE, empty queue, hold=0) → step high in cycle following edge t+1 (2 edges).
- Simultaneous man_req and auto_req: both credited; issued in rr order.
- Reset mid-GAP or mid-ISSUE: immediate return to reset values; queued credits lost.
- step, grant_man and grant_auto are mutually consistent: step == grant_man | grant_auto, and the grants are never both 1.

Decomposition:
- Package gray_sys_pkg: FSM state localparams (IDLE, ISSUE, GAP) and requester index constants (REQ_MAN, REQ_AUTO).
- Sub-module gray_credit_counter (inputs inc, dec; output count, drop), instantiated twice.
- Arbiter/FSM and gap counter live in gray_step_scheduler.
- The existing system instantiates gray_step_scheduler in place of the OR of pulse1 and pulse2; step drives the Gray counter clk_en.

Test Plan:
- Single request: GAP=4, one man_req at edge 10 → step and grant_man high exactly one cycle after edge 11; pend_man returns to 0; no further steps.
- Tie: man_req and auto_req both at edge 10 → step with grant_man after edge 11, step with grant_auto after edge 15; Gray counter advances 2 codes (00→01→11).
- Saturation: hold=1, 9 man_req pulses → pend_man=7 and ovf=1. Release hold → exactly 7 steps, 4 cycles apart; pend_man ends at 0; ovf stays 1.
- Concurrent inc/dec: pend_man=2; man_req in an ISSUE cycle that grants manual → pend_man stays 2 afterwards.
- Hold mid-stream: 3 auto credits, hold raised during the first GAP → that GAP completes, no step while hold=1, pend_auto stays 2. Drop hold → next step on the following edge.
- Async reset: pull rst low mid-GAP with pend_man=5 → all outputs 0 immediately, without waiting for a clk edge. After release, first tie is granted to manual.
